// File: rtl/filter_monitor_pkg.sv
// Package for filter_settle_monitor.
// Holds the measurement FSM state type and the counter width helper that
// both the top and its testbench use to size the sample and band counters.
package filter_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TRACK   = 2'd1,
      SETTLED = 2'd2,
      TIMEOUT = 2'd3
   } state_e;

   // Bits needed to hold every value 0..max_count inclusive.
   function automatic int cnt_width(input int max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/band_detector.sv
// band_detector: classifies one filter output sample against the target band.
//   clk, rst_n    clock, asynchronous active-low reset
//   v_out         signed sample code
//   sample        this sample belongs to the running measurement
//   clear         start of a new measurement; forgets the previous sample
//   in_band       |v_out - TARGET| <= TOL for the current sample
//   above_band    v_out - TARGET > TOL for the current sample
//   prev_in_band  registered in_band of the last accepted sample
module band_detector #(
   parameter int WIDTH  = 18,
   parameter int TARGET = 65536,
   parameter int TOL    = 655
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] v_out,
   input  logic             sample,
   input  logic             clear,
   output logic             in_band,
   output logic             above_band,
   output logic             prev_in_band
);

   // One guard bit makes v_out - TARGET and its magnitude exact.
   localparam logic signed [WIDTH:0] TARGET_S = (WIDTH+1)'(TARGET);
   localparam logic signed [WIDTH:0] TOL_S    = (WIDTH+1)'(TOL);

   logic signed [WIDTH:0] diff;
   logic        [WIDTH:0] abs_diff;
   logic                  in_band_d, in_band_q;

   // NOTE: combinational blocks use blocking '=' and give every output a
   // default first, so no path can leave a value held and infer a latch.
   always_comb begin
      diff       = $signed({v_out[WIDTH-1], v_out}) - TARGET_S;
      abs_diff   = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
      in_band    = (abs_diff <= $unsigned(TOL_S));
      above_band = (diff > TOL_S);

      in_band_d = in_band_q;
      if (clear) begin
         in_band_d = 1'b0;
      end else if (sample) begin
         in_band_d = in_band;
      end
   end

   // NOTE: clocked blocks use non-blocking '<=' so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_band_q <= 1'b0;
      end else begin
         in_band_q <= in_band_d;
      end
   end

   assign prev_in_band = in_band_q;

endmodule

// File: rtl/filter_settle_monitor.sv
// filter_settle_monitor: measures the step response of the emulated filter.
// After a start pulse it tracks v_out samples, reports whether the response
// stays within TOL of TARGET for SETTLE_CYCLES consecutive samples before
// TIMEOUT_CYCLES samples have elapsed, and records peak and overshoot.
//   clk, rst_n   emulator clock, asynchronous active-low reset
//   v_out        signed filter output code (LSB = 2^EXPONENT)
//   sample_en    v_out valid this cycle
//   start        single-cycle pulse; begins or restarts a measurement
//   busy         measurement in progress
//   settled      sticky pass flag
//   timed_out    sticky fail flag
//   overshoot    sticky: a sample exceeded TARGET+TOL
//   peak         largest sample of this measurement
//   settle_time  0-based index of the first sample of the final in-band run
module filter_settle_monitor
   import filter_monitor_pkg::*;
#(
   parameter int WIDTH          = 18,
   parameter int EXPONENT       = -16,
   parameter int TARGET         = 65536,
   parameter int TOL            = 655,
   parameter int SETTLE_CYCLES  = 1000,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic signed [WIDTH-1:0]              v_out,
   input  logic                                 sample_en,
   input  logic                                 start,
   output logic                                 busy,
   output logic                                 settled,
   output logic                                 timed_out,
   output logic                                 overshoot,
   output logic signed [WIDTH-1:0]              peak,
   output logic [cnt_width(TIMEOUT_CYCLES)-1:0] settle_time
);

   localparam int CW = cnt_width(TIMEOUT_CYCLES);
   localparam int BW = cnt_width(SETTLE_CYCLES);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_CYCLES);
   localparam logic [BW-1:0] SETTLE_C  = BW'(SETTLE_CYCLES);
   localparam logic signed [WIDTH-1:0] PEAK_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // Reject configurations that cannot produce a meaningful measurement.
   if (TIMEOUT_CYCLES <= SETTLE_CYCLES || EXPONENT >= 0) begin : g_param_check
      $error("filter_settle_monitor: need TIMEOUT_CYCLES > SETTLE_CYCLES and a fractional EXPONENT");
   end

   state_e                  state_d, state_q;
   logic [CW-1:0]           sample_cnt_d, sample_cnt_q;
   logic [BW-1:0]           band_cnt_d, band_cnt_q;
   logic [CW-1:0]           settle_time_d, settle_time_q;
   logic signed [WIDTH-1:0] peak_d, peak_q;
   logic                    overshoot_d, overshoot_q;
   logic                    clear, take;
   logic                    in_band, above_band, prev_in_band;

   band_detector #(
      .WIDTH  (WIDTH),
      .TARGET (TARGET),
      .TOL    (TOL)
   ) u_band (
      .clk          (clk),
      .rst_n        (rst_n),
      .v_out        (v_out),
      .sample       (take),
      .clear        (clear),
      .in_band      (in_band),
      .above_band   (above_band),
      .prev_in_band (prev_in_band)
   );

   always_comb begin
      state_d       = state_q;
      sample_cnt_d  = sample_cnt_q;
      band_cnt_d    = band_cnt_q;
      settle_time_d = settle_time_q;
      peak_d        = peak_q;
      overshoot_d   = overshoot_q;
      clear         = 1'b0;
      take          = 1'b0;

      unique case (state_q)
         TRACK: begin
            // start outranks a coincident sample: the sample is dropped.
            if (start) begin
               clear = 1'b1;
            end else if (sample_en) begin
               take = 1'b1;
               if (sample_cnt_q != TIMEOUT_C) sample_cnt_d = sample_cnt_q + CW'(1);
               if (in_band) begin
                  if (band_cnt_q != SETTLE_C) band_cnt_d = band_cnt_q + BW'(1);
                  // Index before increment is this sample's 0-based position.
                  if (!prev_in_band) settle_time_d = sample_cnt_q;
               end else begin
                  band_cnt_d = '0;
               end
               if (v_out > peak_q) peak_d = v_out;
               if (above_band) overshoot_d = 1'b1;
               // Settling is tested first so it wins a same-sample tie.
               if (band_cnt_d == SETTLE_C) begin
                  state_d = SETTLED;
               end else if (sample_cnt_d == TIMEOUT_C) begin
                  state_d = TIMEOUT;
               end
            end
         end
         IDLE, SETTLED, TIMEOUT: begin
            if (start) begin
               state_d = TRACK;
               clear   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (clear) begin
         sample_cnt_d  = '0;
         band_cnt_d    = '0;
         settle_time_d = '0;
         peak_d        = PEAK_MIN;
         overshoot_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         sample_cnt_q  <= '0;
         band_cnt_q    <= '0;
         settle_time_q <= '0;
         peak_q        <= PEAK_MIN;
         overshoot_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sample_cnt_q  <= sample_cnt_d;
         band_cnt_q    <= band_cnt_d;
         settle_time_q <= settle_time_d;
         peak_q        <= peak_d;
         overshoot_q   <= overshoot_d;
      end
   end

   assign busy        = (state_q == TRACK);
   assign settled     = (state_q == SETTLED);
   assign timed_out   = (state_q == TIMEOUT);
   assign overshoot   = overshoot_q;
   assign peak        = peak_q;
   assign settle_time = settle_time_q;

endmodule
